// File: rtl/iter_mult_gen_pkg.sv
// Shared types for the iterative multiplier: FSM state encoding and operand mode codes.
package iter_mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        SIGN = 2'd2,
        END  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SS = 2'b01;
    localparam logic [1:0] MODE_SU = 2'b10;
endpackage

// File: rtl/iter_mult_gen_if.sv
// Request/response bundle between the pipeline and the iterative multiplier.
interface iter_mult_gen_if #(parameter int WIDTH = 32);
    logic                 in_valid;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   product;
    logic                 out_valid;
    logic                 stall;

    modport master (output in_valid, mode, mplier, mcand,
                    input  product, out_valid, stall);
    modport slave  (input  in_valid, mode, mplier, mcand,
                    output product, out_valid, stall);
endinterface

// File: rtl/iter_mult_gen_pp.sv
// STEP-bit by WIDTH-bit unsigned partial product, full width so nothing is truncated.
module iter_mult_pp #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [STEP-1:0]       bits,
    input  logic [WIDTH-1:0]      mcand,
    output logic [WIDTH+STEP-1:0] pp
);
    assign pp = (WIDTH+STEP)'(bits) * (WIDTH+STEP)'(mcand);
endmodule

// File: rtl/iter_mult_gen.sv
// Iterative shift-add multiplier: magnitudes in, STEP multiplier bits per cycle,
// early exit once the remaining multiplier is zero, sign fixed up in one final cycle.
module iter_mult_gen
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_mult_gen_if.slave bus
);
    localparam int CYCLES = WIDTH / STEP;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64) ||
            !(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_param
            $error("iter_mult_gen: illegal WIDTH/STEP combination");
        end
    endgenerate

    state_t               state;
    logic [WIDTH-1:0]     mp_mag, mc_mag;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic                 out_valid_q;

    logic                 mp_s, mc_s;
    logic [WIDTH-1:0]     mp_in, mc_in, mp_next;
    logic [WIDTH+STEP-1:0] pp;
    logic [2*WIDTH-1:0]   pp_sh;
    logic                 last;

    // Two's-complement negate yields 2^(WIDTH-1) for the most-negative value, which is the correct magnitude.
    always_comb begin
        mc_s  = (bus.mode == MODE_SS || bus.mode == MODE_SU) && bus.mcand[WIDTH-1];
        mp_s  = (bus.mode == MODE_SS) && bus.mplier[WIDTH-1];
        mp_in = mp_s ? (~bus.mplier + WIDTH'(1)) : bus.mplier;
        mc_in = mc_s ? (~bus.mcand  + WIDTH'(1)) : bus.mcand;
    end

    iter_mult_pp #(.WIDTH(WIDTH), .STEP(STEP)) u_pp (
        .bits  (mp_mag[STEP-1:0]),
        .mcand (mc_mag),
        .pp    (pp)
    );

    assign pp_sh   = (2*WIDTH)'(pp) << (int'(cnt) * STEP);
    assign mp_next = mp_mag >> STEP;
    assign last    = (mp_next == '0) || (cnt == CNT_W'(CYCLES - 1));

    assign bus.stall     = rst_n && ((state == IDLE && bus.in_valid) || state == OP || state == SIGN);
    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mp_mag      <= '0;
            mc_mag      <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    mp_mag <= mp_in;
                    mc_mag <= mc_in;
                    neg    <= mp_s ^ mc_s;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= OP;
                end
                OP: begin
                    acc    <= acc + pp_sh;
                    mp_mag <= mp_next;
                    cnt    <= cnt + 1'b1;
                    if (last) state <= SIGN;
                end
                SIGN: begin
                    product_q   <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    out_valid_q <= 1'b1;
                    state       <= END;
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_mult_gen.sv
// Scoreboard bench: a STEP=1 and a STEP=4 multiplier fed identical operations.
module tb_iter_mult_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    iter_mult_gen_if #(.WIDTH(32)) mif ();
    iter_mult_gen_if #(.WIDTH(32)) mif4 ();

    iter_mult_gen #(.WIDTH(32), .STEP(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
    iter_mult_gen #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(mif4.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] mode, input logic [31:0] mp, input logic [31:0] mc);
        logic [63:0] a, b;
        a = {32'b0, mc};
        b = {32'b0, mp};
        if (mode == 2'b01) begin
            a = {{32{mc[31]}}, mc};
            b = {{32{mp[31]}}, mp};
        end else if (mode == 2'b10) begin
            a = {{32{mc[31]}}, mc};
        end
        return a * b;
    endfunction

    function automatic int lat(input logic [1:0] mode, input logic [31:0] mp, input int step);
        logic [31:0] m;
        int p;
        m = (mode == 2'b01 && mp[31]) ? (~mp + 32'd1) : mp;
        p = -1;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        if (p < 0) return 1;
        return (p + step) / step;
    endfunction

    always @(negedge clk) if (mif.out_valid) begin
        if (q1.size() == 0) chk("spurious_ov_s1", 64'd1, 64'd0);
        else begin
            e1 = q1.pop_front();
            chk("product_s1", mif.product, e1.prod);
            chk("latency_s1", 64'(cyc), 64'(e1.cyc));
        end
    end

    always @(negedge clk) if (mif4.out_valid) begin
        if (q4.size() == 0) chk("spurious_ov_s4", 64'd1, 64'd0);
        else begin
            e4 = q4.pop_front();
            chk("product_s4", mif4.product, e4.prod);
            chk("latency_s4", 64'(cyc), 64'(e4.cyc));
        end
    end

    task automatic drive(input logic v, input logic [1:0] mode, input logic [31:0] mp, input logic [31:0] mc);
        mif.in_valid  = v; mif.mode  = mode; mif.mplier  = mp; mif.mcand  = mc;
        mif4.in_valid = v; mif4.mode = mode; mif4.mplier = mp; mif4.mcand = mc;
    endtask

    // One operation on both DUTs; stall is checked every cycle against the STEP=1 timeline.
    task automatic run_op(input logic [1:0] mode, input logic [31:0] mp, input logic [31:0] mc, input bit poke);
        int t, n1, n4;
        exp_t e;
        @(posedge clk); #1;
        drive(1'b1, mode, mp, mc);
        t  = cyc;
        n1 = lat(mode, mp, 1);
        n4 = lat(mode, mp, 4);
        e.prod = model(mode, mp, mc);
        e.cyc = t + n1 + 2; q1.push_back(e);
        e.cyc = t + n4 + 2; q4.push_back(e);
        @(negedge clk);
        chk("stall_accept", 64'(mif.stall), 64'd1);
        @(posedge clk); #1;
        mif.in_valid = 1'b0; mif4.in_valid = 1'b0;
        for (int k = 1; k <= n1 + 1; k++) begin
            @(negedge clk);
            chk("stall_busy", 64'(mif.stall), 64'd1);
            if (poke && k == 2) drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_1234);
            if (poke && k == 3) begin mif.in_valid = 1'b0; mif4.in_valid = 1'b0; end
        end
        @(negedge clk);
        chk("stall_end", 64'(mif.stall), 64'd0);
        chk("ov_end", 64'(mif.out_valid), 64'd1);
    endtask

    initial begin
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_product", mif.product, 64'd0);
        chk("rst_ov", 64'(mif.out_valid), 64'd0);
        chk("rst_stall", 64'(mif.stall), 64'd0);
        chk("rst_product_s4", mif4.product, 64'd0);
        rst_n = 1'b1;

        run_op(2'b00, 32'd3, 32'd5, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b00, 32'd0, 32'h1234_5678, 1'b0);
        run_op(2'b10, 32'h8000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b11, 32'd2, 32'h8000_0000, 1'b0);
        run_op(2'b01, 32'hFFFF_FFF0, 32'd9, 1'b0);
        run_op(2'b00, 32'h0000_00F0, 32'd9, 1'b1);
        run_op(2'b01, 32'h0000_0005, 32'h7FFF_FFFF, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom_range(0, 3)), $urandom >> $urandom_range(0, 31), $urandom, 1'b0);

        // Abandon a long STEP=1 operation with a one-cycle reset.
        @(posedge clk); #1;
        mif.in_valid = 1'b1; mif.mode = 2'b00; mif.mplier = 32'hFFFF_FFFF; mif.mcand = 32'd3;
        @(posedge clk); #1;
        mif.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("stall_pre_rst", 64'(mif.stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_product", mif.product, 64'd0);
        chk("midrst_stall", 64'(mif.stall), 64'd0);
        chk("midrst_ov", 64'(mif.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_product", mif.product, 64'd0);
        chk("post_rst_stall", 64'(mif.stall), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(posedge clk);
        chk("drain_s1", 64'(q1.size()), 64'd0);
        chk("drain_s4", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/iter_mult_gen.md
ITER_MULT_GEN -- requirements
Module: iter_mult_gen

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter STEP, default 1: multiplier bits consumed per OP cycle; legal values 1, 2, 4; SHALL divide WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and mode valid; sampled only in IDLE.
REQ-006 mode  input  2  00 unsigned x unsigned; 01 signed x signed; 10 signed mcand x unsigned mplier; 11 treated as 00.
REQ-007 mplier  input  WIDTH  multiplier operand.
REQ-008 mcand  input  WIDTH  multiplicand operand.
REQ-009 product  output  2*WIDTH  registered full-width result; held until the next accepted operation.
REQ-010 out_valid  output  1  one-cycle pulse; product is valid in that cycle.
REQ-011 stall  output  1  processor must hold the pipeline while high.

Function
REQ-012 FSM states: IDLE, OP, SIGN, END; encoding from the shared package.
REQ-013 IDLE -> OP when in_valid=1; operands, mode, and result sign (XOR of operand signs per mode) are latched; operands are stored as magnitudes.
REQ-014 Magnitude of the most-negative signed value (-2^(WIDTH-1)) SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit value, with no overflow.
REQ-015 The accumulator SHALL clear to 0 on accept.
REQ-016 Each OP cycle: accumulator += (mplier_mag[STEP-1:0] * mcand_mag) << (cnt*STEP); mplier_mag >>= STEP; cnt += 1.
REQ-017 OP -> SIGN when the shifted mplier_mag is zero (early termination) or cnt reaches WIDTH/STEP-1.
REQ-018 OP cycle count N = max(1, ceil((p+1)/STEP)), where p is the highest set bit of mplier_mag; N = 1 when mplier is 0.
REQ-019 SIGN: the product register SHALL take the two's-complement negation of the accumulator if the result sign is 1, else the accumulator; exactly one cycle.
REQ-020 END: out_valid=1 for exactly one cycle; END -> IDLE unconditionally.
REQ-021 Latency: for in_valid accepted at cycle T, out_valid SHALL be high at cycle T+N+2.
REQ-022 stall=1 in IDLE when in_valid=1, and in OP and SIGN; stall=0 in END and in IDLE when in_valid=0.
REQ-023 in_valid in OP, SIGN, or END SHALL be ignored; operands are not re-latched.
REQ-024 in_valid in the cycle after END SHALL be accepted normally (back-to-back operations).
REQ-025 Arithmetic SHALL be exact modulo 2^(2*WIDTH) for all modes; no intermediate truncation.

Reset
REQ-026 Assertion of rst_n (low) SHALL immediately force state=IDLE, product=0, accumulator=0, cnt=0, latched operands=0, out_valid=0, stall=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no out_valid pulse; the first rising edge with rst_n=1 SHALL behave as IDLE.

Structure
REQ-028 Shared package iter_mult_pkg SHALL hold the state typedef (IDLE, OP, SIGN, END) and the mode constants (MODE_UU, MODE_SS, MODE_SU).
REQ-029 A single sub-module, iter_mult_pp, SHALL produce the STEP-bit x WIDTH-bit partial product; all other logic resides in iter_mult_gen.
REQ-030 A parameter-legality check SHALL fail elaboration for illegal WIDTH/STEP values.

Verification (WIDTH=32, STEP=1 unless stated)
REQ-031 mode=00, mplier=3, mcand=5 at T -> product=15, out_valid at T+4, stall high from T through T+3.
REQ-032 mode=00, both operands 0xFFFFFFFF -> product=0xFFFFFFFE00000001, out_valid at T+34; repeat with STEP=4 -> out_valid at T+10.
REQ-033 mode=01, mplier=7, mcand=0xFFFFFFFD (-3) -> product=0xFFFFFFFFFFFFFFEB, out_valid at T+5; mode=01, both operands 0x80000000 -> product=0x4000000000000000.
REQ-034 mplier=0, mcand=0x12345678 -> product=0, out_valid at T+3.
REQ-035 in_valid pulsed with new operands during OP -> first result unchanged; no second out_valid; a new operation is accepted the cycle after END.
REQ-036 rst_n low for one cycle at T+10 of a 32-cycle operation -> product=0 and stall=0 immediately; no out_valid pulse.
